// File: rtl/verdict_collector.sv
// verdict_collector: queues every monitor cycle with an active output as a record and
// drains records as 64-bit word streams. Optional timestamp word: VERDICT_TIMESTAMP_EN.
module verdict_collector #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] output_0,
  input  logic [63:0] output_1,
  input  logic [63:0] output_2,
  input  logic        output_0_aktv,
  input  logic        output_1_aktv,
  input  logic        output_2_aktv,
  input  logic [63:0] tag,
  output logic [63:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        overflow,
  output logic [15:0] drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_TS   = 2'd2;
  localparam logic [1:0] ST_VAL  = 2'd3;

  logic [63:0] tag_mem  [DEPTH];
  logic [2:0]  mask_mem [DEPTH];
  logic [63:0] val0_mem [DEPTH];
  logic [63:0] val1_mem [DEPTH];
  logic [63:0] val2_mem [DEPTH];
`ifdef VERDICT_TIMESTAMP_EN
  logic [63:0] ts_mem   [DEPTH];
  logic [63:0] ts_reg;
`endif

  logic [1:0]  state_reg, state_next;
  logic [1:0]  vidx_reg, vidx_next;
  logic [AW-1:0] head_reg, tail_reg;
  logic [AW:0] count_reg, count_next;
  logic        overflow_reg;
  logic [15:0] drop_reg;

  logic [2:0]  mask;
  logic [2:0]  head_mask;
  logic        cap_req;
  logic        full;
  logic        handshake;
  logic        push;
  logic        pop;
  logic        drop;
  logic [1:0]  first_idx;
  logic [1:0]  next_idx;
  logic        has_next;

  assign mask      = {output_2_aktv, output_1_aktv, output_0_aktv};
  assign cap_req   = en && (mask != 3'b000);
  assign head_mask = mask_mem[head_reg];
  assign full      = (count_reg == FULL_COUNT);
  assign handshake = m_valid && m_ready;

  // Lowest set mask bit overall, and lowest set bit above the value currently on the bus.
  always_comb begin
    first_idx = 2'd0;
    next_idx  = vidx_reg;
    has_next  = 1'b0;
    for (int k = 2; k >= 0; k--) begin
      if (head_mask[k]) begin
        first_idx = 2'(k);
        if (k > int'(vidx_reg)) begin
          next_idx = 2'(k);
          has_next = 1'b1;
        end
      end
    end
  end

  // A full FIFO still accepts a capture when the head record retires on the same edge.
  assign pop  = handshake && (state_reg == ST_VAL) && !has_next;
  assign push = cap_req && (!full || pop);
  assign drop = cap_req && full && !pop;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + (AW+1)'(1);
    end else if (!push && pop) begin
      count_next = count_reg - (AW+1)'(1);
    end
  end

  always_comb begin
    state_next = state_reg;
    vidx_next  = vidx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (count_reg != '0 || push) begin
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        if (handshake) begin
          vidx_next = first_idx;
`ifdef VERDICT_TIMESTAMP_EN
          state_next = ST_TS;
`else
          state_next = ST_VAL;
`endif
        end
      end
      ST_TS: begin
        if (handshake) begin
          state_next = ST_VAL;
        end
      end
      default: begin
        if (handshake) begin
          if (has_next) begin
            vidx_next = next_idx;
          end else if (count_next != '0) begin
            state_next = ST_HDR;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    m_data = 64'd0;
    case (state_reg)
      ST_HDR: m_data = {tag_mem[head_reg][60:0], head_mask};
      ST_TS: begin
`ifdef VERDICT_TIMESTAMP_EN
        m_data = ts_mem[head_reg];
`else
        m_data = 64'd0;
`endif
      end
      ST_VAL: begin
        case (vidx_reg)
          2'd0:    m_data = val0_mem[head_reg];
          2'd1:    m_data = val1_mem[head_reg];
          default: m_data = val2_mem[head_reg];
        endcase
      end
      default: m_data = 64'd0;
    endcase
  end

  assign m_valid    = (state_reg != ST_IDLE);
  assign m_last     = (state_reg == ST_VAL) && !has_next;
  assign overflow   = overflow_reg;
  assign drop_count = drop_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[tail_reg]  <= tag;
      mask_mem[tail_reg] <= mask;
      val0_mem[tail_reg] <= output_0;
      val1_mem[tail_reg] <= output_1;
      val2_mem[tail_reg] <= output_2;
`ifdef VERDICT_TIMESTAMP_EN
      ts_mem[tail_reg]   <= ts_reg;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      vidx_reg     <= 2'd0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_reg     <= 16'd0;
    end else begin
      state_reg <= state_next;
      vidx_reg  <= vidx_next;
      count_reg <= count_next;
      if (push) begin
        tail_reg <= tail_reg + AW'(1);
      end
      if (pop) begin
        head_reg <= head_reg + AW'(1);
      end
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_reg != 16'hFFFF) begin
          drop_reg <= drop_reg + 16'd1;
        end
      end
    end
  end

`ifdef VERDICT_TIMESTAMP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_reg <= 64'd0;
    end else begin
      ts_reg <= ts_reg + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_verdict_collector.sv
// Directed self-checking bench for verdict_collector (DEPTH=8); inputs driven and
// outputs sampled on the falling edge.
module tb_verdict_collector;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [63:0] output_0, output_1, output_2;
  logic        output_0_aktv, output_1_aktv, output_2_aktv;
  logic [63:0] tag;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        overflow;
  logic [15:0] drop_count;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  verdict_collector #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .output_0(output_0), .output_1(output_1), .output_2(output_2),
    .output_0_aktv(output_0_aktv), .output_1_aktv(output_1_aktv),
    .output_2_aktv(output_2_aktv), .tag(tag),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .overflow(overflow), .drop_count(drop_count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // In the timestamp build a TS word follows each header; step over it.
  task automatic skip_ts();
`ifdef VERDICT_TIMESTAMP_EN
    @(negedge clk);
`endif
  endtask

  // Presents one capture cycle; returns on the falling edge after the capture edge.
  task automatic capture(input logic [63:0] v0, input logic [63:0] v1, input logic [63:0] v2,
                         input logic [2:0] m, input logic [63:0] t, input logic e);
    en = e; output_0 = v0; output_1 = v1; output_2 = v2; tag = t;
    {output_2_aktv, output_1_aktv, output_0_aktv} = m;
    @(negedge clk);
    en = 1'b0;
    {output_2_aktv, output_1_aktv, output_0_aktv} = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; tag = 64'd0;
    output_0 = 64'd0; output_1 = 64'd0; output_2 = 64'd0;
    {output_2_aktv, output_1_aktv, output_0_aktv} = 3'b000;
    repeat (3) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 64'd0)
      $display("FAIL reset_stream: valid=%b last=%b data=%h, want 0 0 0", m_valid, m_last, m_data);
    else passes++;
    checks++;
    if (overflow !== 1'b0 || drop_count !== 16'd0)
      $display("FAIL reset_flags: overflow=%b drop_count=%0d, want 0 0", overflow, drop_count);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0)
      $display("FAIL reset_idle: valid=%b, want 0", m_valid);
    else passes++;
  endtask

  task automatic test_basic();
    logic [63:0] exp_w [4];
    exp_w = '{64'h2F, 64'd1, 64'd2, 64'd3};
    m_ready = 1'b1;
    capture(64'd1, 64'd2, 64'd3, 3'b111, 64'd5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_w[i] || m_last !== (i == 3))
        $display("FAIL basic_word%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 i, m_valid, m_data, m_last, exp_w[i], (i == 3));
      else passes++;
      @(negedge clk);
      if (i == 0) skip_ts();
    end
    checks++;
    if (m_valid !== 1'b0)
      $display("FAIL basic_idle: valid=%b, want 0", m_valid);
    else passes++;
  endtask

  task automatic test_single();
    logic [63:0] exp_w [2];
    exp_w = '{64'h3A, 64'hFFFF_FFFF_FFFF_FFFC};
    m_ready = 1'b1;
    capture(64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 3'b010, 64'd7, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_w[i] || m_last !== (i == 1))
        $display("FAIL single_word%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 i, m_valid, m_data, m_last, exp_w[i], (i == 1));
      else passes++;
      @(negedge clk);
      if (i == 0) skip_ts();
    end
  endtask

  task automatic test_stall();
    logic [63:0] exp_w [4];
    exp_w = '{64'h4F, 64'd10, 64'd20, 64'd30};
    m_ready = 1'b1;
    capture(64'd10, 64'd20, 64'd30, 3'b111, 64'd9, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_w[i] || m_last !== (i == 3))
        $display("FAIL stall_word%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 i, m_valid, m_data, m_last, exp_w[i], (i == 3));
      else passes++;
      if (i == 2) begin
        m_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checks++;
          if (m_valid !== 1'b1 || m_data !== 64'd20 || m_last !== 1'b0)
            $display("FAIL stall_hold%0d: valid=%b data=%h last=%b, want 1 %h 0",
                     s, m_valid, m_data, m_last, 64'd20);
          else passes++;
        end
        m_ready = 1'b1;
      end
      @(negedge clk);
      if (i == 0) skip_ts();
    end
  endtask

  task automatic test_en_gating();
    m_ready = 1'b1;
    capture(64'd1, 64'd1, 64'd1, 3'b111, 64'd1, 1'b0);
    checks++;
    if (m_valid !== 1'b0)
      $display("FAIL en_low_capture: valid=%b, want 0", m_valid);
    else passes++;
    capture(64'd1, 64'd2, 64'd3, 3'b000, 64'd1, 1'b1);
    checks++;
    if (m_valid !== 1'b0)
      $display("FAIL empty_mask_capture: valid=%b, want 0", m_valid);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_w [3];
    exp_w = '{64'hA, 64'h14, 64'hB};
    m_ready = 1'b1;
    en = 1'b1; output_0 = 64'hA; output_1 = 64'd0; output_2 = 64'd0; tag = 64'd1;
    {output_2_aktv, output_1_aktv, output_0_aktv} = 3'b001;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 64'h9 || m_last !== 1'b0)
      $display("FAIL b2b_hdr_a: valid=%b data=%h last=%b, want 1 9 0", m_valid, m_data, m_last);
    else passes++;
    output_0 = 64'd0; output_2 = 64'hB; tag = 64'd2;
    {output_2_aktv, output_1_aktv, output_0_aktv} = 3'b100;
    @(negedge clk);
    en = 1'b0;
    {output_2_aktv, output_1_aktv, output_0_aktv} = 3'b000;
    skip_ts();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_w[i] || m_last !== (i != 1))
        $display("FAIL b2b_word%0d: valid=%b data=%h last=%b, want 1 %h %b",
                 i, m_valid, m_data, m_last, exp_w[i], (i != 1));
      else passes++;
      @(negedge clk);
      if (i == 1) skip_ts();
    end
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; output_0 = 64'(100 + i); output_1 = 64'd0; output_2 = 64'd0; tag = 64'(i);
      {output_2_aktv, output_1_aktv, output_0_aktv} = 3'b001;
      @(negedge clk);
    end
    en = 1'b0;
    {output_2_aktv, output_1_aktv, output_0_aktv} = 3'b000;
    checks++;
    if (overflow !== 1'b1 || drop_count !== 16'd2)
      $display("FAIL overflow_flags: overflow=%b drop_count=%0d, want 1 2", overflow, drop_count);
    else passes++;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 64'h1)
      $display("FAIL overflow_held_hdr: valid=%b data=%h, want 1 1", m_valid, m_data);
    else passes++;
    m_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== 64'((r << 3) | 1) || m_last !== 1'b0)
        $display("FAIL overflow_hdr%0d: valid=%b data=%h last=%b, want 1 %h 0",
                 r, m_valid, m_data, m_last, 64'((r << 3) | 1));
      else passes++;
      @(negedge clk);
      skip_ts();
      checks++;
      if (m_valid !== 1'b1 || m_data !== 64'(100 + r) || m_last !== 1'b1)
        $display("FAIL overflow_val%0d: valid=%b data=%h last=%b, want 1 %h 1",
                 r, m_valid, m_data, m_last, 64'(100 + r));
      else passes++;
      @(negedge clk);
    end
    checks++;
    if (m_valid !== 1'b0)
      $display("FAIL overflow_drained: valid=%b, want 0", m_valid);
    else passes++;
  endtask

  task automatic test_full_coincide();
    logic [63:0] exp_tag;
    logic [63:0] exp_val;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; output_0 = 64'(200 + i); tag = 64'(16 + i);
      {output_2_aktv, output_1_aktv, output_0_aktv} = 3'b001;
      @(negedge clk);
    end
    en = 1'b0;
    {output_2_aktv, output_1_aktv, output_0_aktv} = 3'b000;
    checks++;
    if (drop_count !== 16'd2)
      $display("FAIL full_fill_nodrop: drop_count=%0d, want 2", drop_count);
    else passes++;
    m_ready = 1'b1;
    @(negedge clk);
    skip_ts();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 64'd200 || m_last !== 1'b1)
      $display("FAIL full_last_word: valid=%b data=%h last=%b, want 1 %h 1",
               m_valid, m_data, m_last, 64'd200);
    else passes++;
    en = 1'b1; output_0 = 64'd300; tag = 64'd40;
    {output_2_aktv, output_1_aktv, output_0_aktv} = 3'b001;
    @(negedge clk);
    en = 1'b0;
    {output_2_aktv, output_1_aktv, output_0_aktv} = 3'b000;
    checks++;
    if (drop_count !== 16'd2 || overflow !== 1'b1)
      $display("FAIL full_coincide_nodrop: drop_count=%0d overflow=%b, want 2 1", drop_count, overflow);
    else passes++;
    for (int r = 1; r < 9; r++) begin
      exp_tag = (r == 8) ? 64'd40 : 64'(16 + r);
      exp_val = (r == 8) ? 64'd300 : 64'(200 + r);
      checks++;
      if (m_valid !== 1'b1 || m_data !== {exp_tag[60:0], 3'b001} || m_last !== 1'b0)
        $display("FAIL full_hdr%0d: valid=%b data=%h last=%b, want 1 %h 0",
                 r, m_valid, m_data, m_last, {exp_tag[60:0], 3'b001});
      else passes++;
      @(negedge clk);
      skip_ts();
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp_val || m_last !== 1'b1)
        $display("FAIL full_val%0d: valid=%b data=%h last=%b, want 1 %h 1",
                 r, m_valid, m_data, m_last, exp_val);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    capture(64'd5, 64'd6, 64'd7, 3'b111, 64'd3, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || overflow !== 1'b0 || drop_count !== 16'd0)
      $display("FAIL midreset_clear: valid=%b last=%b overflow=%b drop_count=%0d, want 0 0 0 0",
               m_valid, m_last, overflow, drop_count);
    else passes++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (m_valid !== 1'b0)
      $display("FAIL midreset_quiet: valid=%b, want 0", m_valid);
    else passes++;
    capture(64'd0, 64'd0, 64'd77, 3'b100, 64'd6, 1'b1);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 64'h34 || m_last !== 1'b0)
      $display("FAIL midreset_hdr: valid=%b data=%h last=%b, want 1 34 0", m_valid, m_data, m_last);
    else passes++;
    @(negedge clk);
    skip_ts();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 64'd77 || m_last !== 1'b1)
      $display("FAIL midreset_val: valid=%b data=%h last=%b, want 1 %h 1",
               m_valid, m_data, m_last, 64'd77);
    else passes++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; tag = 64'd0;
    output_0 = 64'd0; output_1 = 64'd0; output_2 = 64'd0;
    {output_2_aktv, output_1_aktv, output_0_aktv} = 3'b000;
    @(negedge clk);
    test_reset();
    test_basic();
    test_single();
    test_stall();
    test_en_gating();
    test_back_to_back();
    test_overflow();
    test_full_coincide();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
